// File: rtl/bp_lce_req_stream_pkg.sv
// BedRock LCE request message types and beat arithmetic
// shared by the LCE request streamer.
package bp_lce_req_stream_pkg;

  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 512;
  localparam int lce_id_width_p    = 2;
  localparam int cce_id_width_p    = 2;
  localparam int lce_assoc_p       = 8;
  localparam int lg_lce_assoc_lp   = $clog2(lce_assoc_p);

  typedef enum logic [3:0] {
    e_bedrock_req_rd    = 4'd0,
    e_bedrock_req_wr    = 4'd1,
    e_bedrock_req_uc_rd = 4'd2,
    e_bedrock_req_uc_wr = 4'd3
  } bp_bedrock_req_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    bp_bedrock_req_type_e req;
  } bp_bedrock_msg_type_s;

  typedef struct packed {
    logic [lg_lce_assoc_lp-1:0] lru_way_id;
    logic [cce_id_width_p-1:0]  dst_id;
    logic [lce_id_width_p-1:0]  src_id;
  } bp_bedrock_lce_req_payload_s;

  typedef struct packed {
    bp_bedrock_lce_req_payload_s payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_p-1:0]    addr;
    bp_bedrock_msg_type_s        msg_type;
  } bp_bedrock_lce_req_header_s;

  localparam int lce_req_msg_header_width_lp =
    $bits(bp_bedrock_lce_req_header_s);

  typedef enum logic [1:0] {
    e_reset,
    e_ready,
    e_send_header,
    e_send_data
  } bp_lce_req_stream_state_e;

  // Sub-beat sizes still occupy one beat; oversize clamps to the buffer.
  function automatic int beats_minus_one(
    input logic [2:0] size,
    input int         beat_width,
    input int         beats
  );
    int n;
    n = (8 << size) / beat_width;
    if (n < 1) n = 1;
    if (n > beats) n = beats;
    return n - 1;
  endfunction

endpackage

// File: rtl/bp_lce_req_stream_counter.sv
// Beat counter: synchronous clear and increment,
// clear taking priority.
module bp_lce_req_stream_counter
  import bp_lce_req_stream_pkg::*;
#(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= '0;
    else if (clear_i)
      count_o <= '0;
    else if (up_i)
      count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bp_lce_req_stream.sv
// Buffers one LCE request and streams it as a header
// followed by zero or more data beats.
module bp_lce_req_stream
  import bp_lce_req_stream_pkg::*;
#(
  parameter int data_width_p = cce_block_width_p,
  parameter int beat_width_p = 64,
  localparam int beats_lp    = data_width_p / beat_width_p,
  localparam int lg_beats_lp =
    (beats_lp > 1) ? $clog2(beats_lp) : 1,
  localparam int msg_width_lp =
    lce_req_msg_header_width_lp + data_width_p
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [msg_width_lp-1:0]       lce_req_i,
  input  logic                          lce_req_v_i,
  output logic                          lce_req_ready_o,
  output bp_bedrock_lce_req_header_s    lce_req_header_o,
  output logic                          lce_req_has_data_o,
  output logic                          lce_req_header_v_o,
  input  logic                          lce_req_header_ready_i,
  output logic [beat_width_p-1:0]       lce_req_data_o,
  output logic                          lce_req_data_v_o,
  output logic                          lce_req_data_last_o,
  input  logic                          lce_req_data_ready_i
);

  bp_lce_req_stream_state_e state_r, state_n;

  bp_bedrock_lce_req_header_s             header_r;
  logic [beats_lp-1:0][beat_width_p-1:0]  data_r;
  logic [lg_beats_lp-1:0]                 count_r;
  logic [lg_beats_lp-1:0]                 last_beat;
  logic accept, beat_done, has_data, is_last;

  assign accept    = lce_req_v_i & lce_req_ready_o;
  assign beat_done = lce_req_data_v_o & lce_req_data_ready_i;

  always_ff @(posedge clk_i) begin
    if (accept)
      {data_r, header_r} <= lce_req_i;
  end

  assign has_data =
    (header_r.msg_type.req == e_bedrock_req_uc_wr);
  assign last_beat = lg_beats_lp'(
    beats_minus_one(header_r.size, beat_width_p, beats_lp));
  assign is_last = (count_r == last_beat);

  bp_lce_req_stream_counter #(
    .width_p (lg_beats_lp)
  ) u_count (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (accept),
    .up_i    (beat_done),
    .count_o (count_r)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_r <= e_reset;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n            = state_r;
    lce_req_ready_o    = 1'b0;
    lce_req_header_v_o = 1'b0;
    lce_req_data_v_o   = 1'b0;
    unique case (state_r)
      e_reset: state_n = e_ready;
      e_ready: begin
        lce_req_ready_o = 1'b1;
        if (lce_req_v_i)
          state_n = e_send_header;
      end
      e_send_header: begin
        lce_req_header_v_o = 1'b1;
        if (lce_req_header_ready_i)
          state_n = has_data ? e_send_data : e_ready;
      end
      e_send_data: begin
        lce_req_data_v_o = 1'b1;
        if (lce_req_data_ready_i && is_last)
          state_n = e_ready;
      end
      default: state_n = e_reset;
    endcase
  end

  assign lce_req_header_o    = header_r;
  assign lce_req_has_data_o  = has_data;
  assign lce_req_data_o      = data_r[count_r];
  assign lce_req_data_last_o = lce_req_data_v_o & is_last;

endmodule

// File: tb/tb_bp_lce_req_stream.sv
// Directed bench for bp_lce_req_stream with a header/beat
// scoreboard checked on every output handshake.
module tb_bp_lce_req_stream;
  import bp_lce_req_stream_pkg::*;

  localparam int dw = 512;
  localparam int bw = 64;
  localparam int nb = dw / bw;
  localparam int hw = lce_req_msg_header_width_lp;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [hw+dw-1:0] lce_req_i = '0;
  logic lce_req_v_i = 1'b0;
  logic ready;
  bp_bedrock_lce_req_header_s header_o;
  logic has_data, hv, header_ready;
  logic [bw-1:0] data_o;
  logic dv, last, data_ready;

  always #5 clk = ~clk;

  bp_lce_req_stream #(
    .data_width_p (dw),
    .beat_width_p (bw)
  ) dut (
    .clk_i                  (clk),
    .reset_i                (reset_i),
    .lce_req_i              (lce_req_i),
    .lce_req_v_i            (lce_req_v_i),
    .lce_req_ready_o        (ready),
    .lce_req_header_o       (header_o),
    .lce_req_has_data_o     (has_data),
    .lce_req_header_v_o     (hv),
    .lce_req_header_ready_i (header_ready),
    .lce_req_data_o         (data_o),
    .lce_req_data_v_o       (dv),
    .lce_req_data_last_o    (last),
    .lce_req_data_ready_i   (data_ready)
  );

  logic [hw:0] hq[$];
  logic [bw:0] dq[$];
  logic [hw:0] he;
  logic [bw:0] de;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bp_bedrock_lce_req_header_s mk(
    input bp_bedrock_req_type_e t,
    input logic [2:0] sz,
    input logic [39:0] a
  );
    bp_bedrock_lce_req_header_s h;
    h = '0;
    h.msg_type.req = t;
    h.size = bp_bedrock_msg_size_e'(sz);
    h.addr = a;
    h.payload.src_id = 2'd1;
    return h;
  endfunction

  task automatic send(input bp_bedrock_lce_req_header_s h,
                      input logic [dw-1:0] d);
    logic wr;
    wr = (h.msg_type.req == e_bedrock_req_uc_wr);
    hq.push_back({wr, h});
    if (wr) begin
      int n;
      n = (8 << h.size) / bw;
      if (n < 1) n = 1;
      if (n > nb) n = nb;
      for (int k = 0; k < n; k++)
        dq.push_back({k == n - 1, d[k*bw +: bw]});
    end
    lce_req_i = {d, h};
    lce_req_v_i = 1'b1;
    for (int w = 0; w < 20 && !ready; w++) tick();
    chk("send_ready", ready, 1);
    tick();
    lce_req_v_i = 1'b0;
  endtask

  // Output scoreboard
  always @(negedge clk) begin
    if (!reset_i) begin
      chk("valid_excl", hv & dv, 0);
      if (hv && header_ready) begin
        if (hq.size() == 0) chk("hdr_extra", 1, 0);
        else begin
          he = hq.pop_front();
          chk("hdr", {has_data, header_o}, he);
        end
      end
      if (dv && data_ready) begin
        if (dq.size() == 0) chk("beat_extra", 1, 0);
        else begin
          de = dq.pop_front();
          chk("beat", {last, data_o}, de);
        end
      end
    end
  end

  logic [dw-1:0] d;
  bp_bedrock_lce_req_header_s h;
  logic [bw-1:0] pd;
  logic stall;

  initial begin
    header_ready = 1'b1;
    data_ready = 1'b1;
    tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_hv", hv, 0);
    chk("rst_dv", dv, 0);
    chk("rst_last", last, 0);
    reset_i = 1'b0;
    chk("rst_state_cycle", ready, 0);
    tick();
    chk("rst_ready_up", ready, 1);

    // uc_wr 8 bytes, single beat
    d = '0;
    d[63:0] = 64'hDEADBEEF_CAFEF00D;
    d[127:64] = 64'h1111_2222_3333_4444;
    send(mk(e_bedrock_req_uc_wr, 3'd3, 40'h1000), d);
    chk("t1_hv", hv, 1);
    chk("t1_has_data", has_data, 1);
    chk("t1_ready_low", ready, 0);
    tick();
    chk("t1_dv", dv, 1);
    chk("t1_data", data_o, 64'hDEADBEEF_CAFEF00D);
    chk("t1_last", last, 1);
    tick();
    chk("t1_ready", ready, 1);
    chk("t1_dv_done", dv, 0);

    // cached read, header only
    send(mk(e_bedrock_req_rd, 3'd6, 40'h2040), '1);
    chk("t2_hv", hv, 1);
    chk("t2_has_data", has_data, 0);
    tick();
    chk("t2_ready", ready, 1);
    chk("t2_dv", dv, 0);

    // uc_wr 64 bytes with data_ready toggling
    d = '0;
    for (int k = 0; k < nb; k++) d[k*bw +: bw] = 64'(k);
    data_ready = 1'b0;
    send(mk(e_bedrock_req_uc_wr, 3'd6, 40'h3000), d);
    for (int i = 0; i < 60 && !ready; i++) begin
      stall = dv && !data_ready;
      pd = data_o;
      tick();
      if (stall) chk("t3_hold", {dv, data_o}, {1'b1, pd});
      data_ready = ~data_ready;
    end
    chk("t3_done", ready, 1);
    chk("t3_beats_left", dq.size(), 0);
    data_ready = 1'b1;

    // header stall with ignored request pulses
    header_ready = 1'b0;
    h = mk(e_bedrock_req_uc_rd, 3'd3, 40'h4008);
    send(h, '0);
    for (int i = 0; i < 5; i++) begin
      lce_req_v_i = i[0];
      lce_req_i = {{dw{1'b1}}, mk(e_bedrock_req_uc_wr,
                                 3'd7, 40'hBAD)};
      tick();
      chk("t4_hv", hv, 1);
      chk("t4_hdr", header_o, h);
      chk("t4_ready", ready, 0);
    end
    lce_req_v_i = 1'b0;
    header_ready = 1'b1;
    tick();
    chk("t4_ready_back", ready, 1);
    tick();
    chk("t4_no_extra_hv", hv, 0);
    chk("t4_q_empty", hq.size(), 0);

    // uc_wr 128 bytes clamps to the buffer
    for (int k = 0; k < nb; k++)
      d[k*bw +: bw] = 64'h100 + 64'(k);
    send(mk(e_bedrock_req_uc_wr, 3'd7, 40'h5000), d);
    for (int i = 0; i < 30 && !ready; i++) tick();
    chk("t5_done", ready, 1);
    chk("t5_beats_left", dq.size(), 0);

    // reset during beat 3 of an 8-beat write
    for (int k = 0; k < nb; k++)
      d[k*bw +: bw] = 64'hA00 + 64'(k);
    send(mk(e_bedrock_req_uc_wr, 3'd6, 40'h6000), d);
    tick(); tick(); tick(); tick();
    chk("t6_beat3", data_o, 64'hA03);
    reset_i = 1'b1;
    tick();
    chk("t6_hv", hv, 0);
    chk("t6_dv", dv, 0);
    chk("t6_ready", ready, 0);
    chk("t6_left", dq.size(), 5);
    dq.delete();
    reset_i = 1'b0;
    chk("t6_reset_cycle", ready, 0);
    tick();
    chk("t6_ready_up", ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_quiet", {hv, dv}, 0);
    end
    chk("end_hq", hq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_lce_req_stream.md
# bp_lce_req_stream

Downstream neighbour of the LCE request handler. Accepts one complete BedRock LCE request message (header plus data) per ready→valid handshake and emits it on the coherence network as a header channel followed by zero or more fixed-width data beats. Only uncached writes (`e_bedrock_req_uc_wr`) carry data. Read requests, both cached and uncached, and cached write requests are header-only. The block sits between the LCE request handler's `lce_req_o` port and the LCE→CCE request network link.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: processor configuration. Provides `paddr_width_p`, `cce_block_width_p`, `lce_id_width_p`, `cce_id_width_p` and `lce_assoc_p`.
- `data_width_p`, `cce_block_width_p`: width of the message data field.
- `beat_width_p`, 64: width of one data beat. Must be a power of two, ≥64, and must divide `data_width_p`.
- Derived: `beats_lp = data_width_p/beat_width_p`; `lg_beats_lp = BSG_SAFE_CLOG2(beats_lp)`.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `lce_req_i`  in  `lce_req_msg_width_lp`  full request message (header + data).
- `lce_req_v_i`  in  1  message valid.
- `lce_req_ready_o`  out  1  ready; this is registered state only and never depends on `lce_req_v_i`.
- `lce_req_header_o`  out  `lce_req_msg_header_width_lp`  buffered header.
- `lce_req_has_data_o`  out  1  high when data beats follow this header.
- `lce_req_header_v_o`  out  1  header valid.
- `lce_req_header_ready_i`  in  1  valid&ready handshake on the header channel.
- `lce_req_data_o`  out  `beat_width_p`  data beat.
- `lce_req_data_v_o`  out  1  data valid.
- `lce_req_data_last_o`  out  1  final beat of the message.
- `lce_req_data_ready_i`  in  1  valid&ready handshake on the data channel.

## Operation
- Single-entry message buffer. It loads on `lce_req_v_i & lce_req_ready_o`.
- State machine:
  - `e_reset`: go to `e_ready`.
  - `e_ready`: `lce_req_ready_o=1`. On accept, load the buffer, clear the beat counter and go to `e_send_header`.
  - `e_send_header`: `lce_req_header_v_o=1`. On handshake, go to `e_send_data` if `has_data`, else go to `e_ready`.
  - `e_send_data`: `lce_req_data_v_o=1`. On handshake, increment the counter. On the last-beat handshake, go to `e_ready`.
- `has_data = (header.msg_type.req == e_bedrock_req_uc_wr)`.
- Beat count:
  - `bytes = 1 << header.size`, where size 0..7 maps to 1..128 B.
  - `n = max(1, bytes*8/beat_width_p)`, clamped to `beats_lp` when the size exceeds `data_width_p`.
  - Compute `n-1` in `lg_beats_lp` bits.
- Beat k drives `data[k*beat_width_p +: beat_width_p]`, unmodified. Sub-beat sizes send beat 0 as-is; the upper bits are whatever upstream supplied.
- `lce_req_data_last_o = (count_r == n-1)` while `lce_req_data_v_o` is high.
- Header and data outputs come straight from registers and hold stable while stalled.
- Any undefined state goes to `e_reset`.

## Timing
- Reset values: `lce_req_ready_o=0`, `lce_req_header_v_o=0`, `lce_req_data_v_o=0`, `lce_req_data_last_o=0`. The state is `e_reset` for the cycle after reset deasserts, then `lce_req_ready_o=1`.
- Latency:
  - Accept at cycle N gives `header_v_o` at N+1.
  - Header handshake at cycle M gives the first beat at M+1 (or `ready_o` at M+1 if there is no data).
  - Final beat handshake at cycle P gives `ready_o` at P+1.
- Throughput: one message per 2+n cycles with zero backpressure.
- Header and data valids are never high in the same cycle. Data is never issued before its header.
- Reset mid-operation discards the buffered message. All valids are low in the cycle after reset is asserted, and no partial beats follow.
- `lce_req_v_i` while `ready_o=0` is ignored. Upstream must hold the message.

## Structure
- Shared package `bp_common_pkg` (existing) provides the BedRock msg structs and `bp_bedrock_msg_size_e`.
- No new package constants are needed; the beat arithmetic is local.
- Natural sub-module: `bsg_counter_clear_up` for the beat counter. The message buffer is a `bsg_dff_en`.

## Test plan
Parameters: `data_width_p=512`, `beat_width_p=64`.
- uc_wr, size 3 (8 B), data[63:0]=0xDEADBEEF_CAFEF00D, all readies high → header at N+1 with has_data=1, one beat at N+2 with data=0xDEADBEEF_CAFEF00D and last=1, `ready_o` at N+3.
- Cached rd, size 6 (64 B) → header only with has_data=0; `data_v_o` is never asserted; `ready_o` returns the cycle after the header handshake.
- uc_wr, size 6, data beats 0x0..0x7 in 64-bit lanes, `data_ready_i` toggling 1,0,1,0… → 8 beats in order 0..7, last only on beat 7, `data_o` stable during stalls.
- `header_ready_i` low for 5 cycles → header and `header_v_o` held constant for 5 cycles and `ready_o` stays 0; `lce_req_v_i` pulses during the stall are ignored.
- uc_wr, size 7 (128 B > 512 b) → clamped to 8 beats, last on beat 7.
- `reset_i` asserted during beat 3 of an 8-beat uc_wr → all valids 0 in the next cycle, one `e_reset` cycle, then `ready_o=1` with no residual beats.
